// File: rtl/adc_capture_ctrl.sv
// Acquisition sequencer: arms on start, waits for a trigger, then writes a
// decimated burst of {ch1, ch2} sample pairs into an external sample RAM.
module adc_capture_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 14
) (
   input  logic                  clk_design,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_W-1:0]     adc_ch1,
   input  logic [DATA_W-1:0]     adc_ch2,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_W-1:0]     cfg_len,
   input  logic [7:0]            cfg_decim,
   input  logic [1:0]            cfg_trig_mode,
   input  logic [DATA_W-1:0]     cfg_thresh,
   input  logic                  ext_trig,
   output logic                  wr_en,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [2*DATA_W-1:0]   wr_data,
   output logic                  armed,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W:0]       sample_count
);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

   state_t                    state, state_nx;
   logic signed [DATA_W-1:0]  ch1_p0, ch2_p0, ch1_p1;
   logic                      vld_p0;
   logic [ADDR_W-1:0]         addr, len_q;
   logic [7:0]                decim_cnt, decim_q;
   logic [1:0]                mode_q;
   logic signed [DATA_W-1:0]  thresh_q;
   logic                      arm_go, wr_go, trig_hit;

   function automatic logic cross_up(input logic signed [DATA_W-1:0] prev,
                                     input logic signed [DATA_W-1:0] cur,
                                     input logic signed [DATA_W-1:0] th);
      return (prev < th) && (cur >= th);
   endfunction

   function automatic logic cross_dn(input logic signed [DATA_W-1:0] prev,
                                     input logic signed [DATA_W-1:0] cur,
                                     input logic signed [DATA_W-1:0] th);
      return (prev >= th) && (cur < th);
   endfunction

   // Stage p0/p1: sample registers; data path carries no reset
   always_ff @(posedge clk_design) begin
      if (en) begin
         ch1_p0 <= adc_ch1;
         ch2_p0 <= adc_ch2;
         ch1_p1 <= ch1_p0;
      end
   end

   // vld_p0 marks that ch1_p1 holds a sample taken after the latest arm
   always_ff @(posedge clk_design) begin
      if (rst)
         vld_p0 <= 1'b0;
      else if (en)
         vld_p0 <= !arm_go;
   end

   always_comb begin
      trig_hit = 1'b0;
      case (mode_q)
         2'b01:   trig_hit = vld_p0 && cross_up(ch1_p1, ch1_p0, thresh_q);
         2'b10:   trig_hit = vld_p0 && cross_dn(ch1_p1, ch1_p0, thresh_q);
         2'b11:   trig_hit = ext_trig;
         default: trig_hit = 1'b1;
      endcase
   end

   always_comb begin
      state_nx = state;
      arm_go   = 1'b0;
      wr_go    = 1'b0;
      if (en) begin
         if (abort) begin
            state_nx = IDLE;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (start) begin
                     arm_go   = 1'b1;
                     state_nx = (cfg_trig_mode == 2'b00) ? CAPTURE : ARMED;
                  end
               end
               ARMED: begin
                  if (trig_hit)
                     state_nx = CAPTURE;
               end
               CAPTURE: begin
                  if (decim_cnt == '0) begin
                     wr_go = 1'b1;
                     if (addr == len_q)
                        state_nx = DONE;
                  end
               end
               default: state_nx = IDLE;
            endcase
         end
      end
   end

   // Stage p1: control state and registered RAM write port
   always_ff @(posedge clk_design) begin
      if (rst) begin
         state        <= IDLE;
         addr         <= '0;
         decim_cnt    <= '0;
         sample_count <= '0;
         len_q        <= '0;
         decim_q      <= '0;
         mode_q       <= '0;
         thresh_q     <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         armed        <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else if (en) begin
         state <= state_nx;
         armed <= (state_nx == ARMED);
         // busy lingers through the cycle of the final write so it drops with done's rise
         busy  <= (state_nx == ARMED) || (state_nx == CAPTURE) ||
                  (state == CAPTURE && state_nx == DONE);
         done  <= (state == DONE) && (state_nx == DONE);
         wr_en <= wr_go;
         if (arm_go) begin
            len_q        <= cfg_len;
            decim_q      <= cfg_decim;
            mode_q       <= cfg_trig_mode;
            thresh_q     <= cfg_thresh;
            addr         <= '0;
            decim_cnt    <= '0;
            sample_count <= '0;
         end
         if (wr_go) begin
            wr_addr      <= addr;
            wr_data      <= {ch1_p0, ch2_p0};
            sample_count <= sample_count + (ADDR_W+1)'(1);
            if (state_nx == CAPTURE)
               addr <= addr + ADDR_W'(1);
         end
         if (state == CAPTURE && !abort)
            decim_cnt <= (decim_cnt == decim_q) ? '0 : decim_cnt + 8'd1;
      end else begin
         wr_en <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: expected RAM writes (cycle, addr, data)
// are queued as stimulus is issued and checked by an independent monitor.
module tb_adc_capture_ctrl;
   localparam int AW = 10;
   localparam int DW = 14;

   typedef struct packed {
      int unsigned     cyc;
      logic [AW-1:0]   addr;
      logic [2*DW-1:0] data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst, en, start, abort, ext_trig;
   logic [DW-1:0]     adc_ch1, adc_ch2, cfg_thresh;
   logic [AW-1:0]     cfg_len;
   logic [7:0]        cfg_decim;
   logic [1:0]        cfg_trig_mode;
   logic              wr_en, armed, busy, done;
   logic [AW-1:0]     wr_addr;
   logic [2*DW-1:0]   wr_data;
   logic [AW:0]       sample_count;

   int                cyc = 0;
   int                n_tests = 0;
   int                n_fail = 0;
   wr_t               exp_q[$];

   int                pat = 0;
   int                step_k = 0;
   logic signed [DW-1:0] lo = '0, hi = '0;

   adc_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_design(clk), .rst(rst), .en(en),
      .adc_ch1(adc_ch1), .adc_ch2(adc_ch2),
      .start(start), .abort(abort),
      .cfg_len(cfg_len), .cfg_decim(cfg_decim), .cfg_trig_mode(cfg_trig_mode),
      .cfg_thresh(cfg_thresh), .ext_trig(ext_trig),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .armed(armed), .busy(busy), .done(done), .sample_count(sample_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] g1(input int c);
      logic [31:0] cv;
      cv = c;
      if (pat == 0) return cv[DW-1:0];
      return (c < step_k) ? lo : hi;
   endfunction

   function automatic logic [DW-1:0] g2(input int c);
      logic [31:0] cv;
      cv = c;
      return cv[DW-1:0] ^ 14'h2A5A;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      adc_ch1 = g1(cyc);
      adc_ch2 = g2(cyc);
   endtask

   task automatic run_until(input int c);
      while (cyc < c) step();
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic push_wr(input int c, input int a, input int src);
      wr_t e;
      logic [31:0] av;
      av     = a;
      e.cyc  = c;
      e.addr = av[AW-1:0];
      e.data = {g1(src), g2(src)};
      exp_q.push_back(e);
   endtask

   task automatic cfg_start(input logic [1:0] mode, input int len, input int decim, input int th);
      logic [31:0] lv, dv, tv;
      lv = len; dv = decim; tv = th;
      cfg_trig_mode = mode;
      cfg_len       = lv[AW-1:0];
      cfg_decim     = dv[7:0];
      cfg_thresh    = tv[DW-1:0];
      start         = 1'b1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wr_en"}, wr_en, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_wr_data"}, wr_data, 0);
      chk({tag, "_armed"}, armed, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_sample_count"}, sample_count, 0);
   endtask

   // Trigger capture of 4 pairs; ch1 steps from b to a at cycle k = T+5
   task automatic trig_test(input logic [1:0] mode, input int th, input int b, input int a);
      int t, k, d;
      logic [31:0] bv, av;
      bv = b; av = a;
      pat = 1; lo = bv[DW-1:0]; hi = av[DW-1:0];
      t = cyc + 1;
      k = t + 5;
      step_k = k;
      step();
      cfg_start(mode, 3, 0, th);
      d = (mode == 2'b11) ? k : k + 1;
      for (int i = 0; i < 4; i++) push_wr(d + 2 + i, i, d + i);
      step();
      start = 1'b0;
      run_until(d);
      chk("trig_armed_wait", armed, 1);
      if (mode == 2'b11) ext_trig = 1'b1;
      step();
      ext_trig = 1'b0;
      chk("trig_armed_clear", armed, 0);
      chk("trig_busy", busy, 1);
      run_until(d + 6);
      chk("trig_done", done, 1);
      chk("trig_count", sample_count, 4);
      chk("trig_queue_empty", exp_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got cyc %0d addr %0d data %0h, expected no write",
                     cyc, wr_addr, wr_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (e.cyc != cyc || wr_addr !== e.addr || wr_data !== e.data) begin
               n_fail++;
               $display("FAIL ram_write: got cyc %0d addr %0d data %0h, expected cyc %0d addr %0d data %0h",
                        cyc, wr_addr, wr_data, e.cyc, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, u;
      rst = 1'b1; en = 1'b1; start = 1'b0; abort = 1'b0; ext_trig = 1'b0;
      adc_ch1 = '0; adc_ch2 = '0; cfg_thresh = '0; cfg_len = '0;
      cfg_decim = '0; cfg_trig_mode = '0;
      repeat (3) step();
      chk_zero("reset");
      rst = 1'b0;

      // Immediate capture, 8 consecutive pairs of a ramp
      pat = 0;
      t = cyc + 1;
      step();
      cfg_start(2'b00, 7, 0, 0);
      for (int i = 0; i < 8; i++) push_wr(t + 2 + i, i, t + i);
      step();
      start = 1'b0;
      run_until(t + 9);
      chk("imm_done_before", done, 0);
      chk("imm_busy_last_write", busy, 1);
      step();
      chk("imm_done", done, 1);
      chk("imm_busy", busy, 0);
      chk("imm_count", sample_count, 8);
      chk("imm_queue_empty", exp_q.size(), 0);

      trig_test(2'b01, 100, 50, 150);
      trig_test(2'b01, -100, -500, 50);
      trig_test(2'b10, 0, 200, -200);
      trig_test(2'b11, 0, 0, 0);

      // Decimation by 4 with en low for 5 cycles between writes
      pat = 0;
      t = cyc + 1;
      step();
      cfg_start(2'b00, 3, 3, 0);
      push_wr(t + 2, 0, t);
      push_wr(t + 6, 1, t + 4);
      push_wr(t + 15, 2, t + 13);
      push_wr(t + 19, 3, t + 17);
      step();
      start = 1'b0;
      run_until(t + 6);
      en = 1'b0;
      run_until(t + 11);
      en = 1'b1;
      run_until(t + 19);
      chk("decim_done_before", done, 0);
      step();
      chk("decim_done", done, 1);
      chk("decim_count", sample_count, 4);
      chk("decim_queue_empty", exp_q.size(), 0);

      // Abort after two writes, on a cycle that would otherwise write
      t = cyc + 1;
      step();
      cfg_start(2'b00, 7, 1, 0);
      push_wr(t + 2, 0, t);
      push_wr(t + 4, 1, t + 2);
      step();
      start = 1'b0;
      run_until(t + 5);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_armed", armed, 0);
      chk("abort_done", done, 0);
      chk("abort_count", sample_count, 2);
      run_until(t + 12);
      chk("abort_queue_empty", exp_q.size(), 0);

      // start and abort together from IDLE: abort wins
      step();
      cfg_start(2'b00, 3, 0, 0);
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_busy", busy, 0);
      chk("start_abort_count", sample_count, 2);
      repeat (5) step();
      chk("start_abort_queue_empty", exp_q.size(), 0);

      // Reset while armed
      pat = 1; lo = '0; hi = '0; step_k = 0;
      t = cyc + 1;
      step();
      cfg_start(2'b01, 3, 0, 100);
      step();
      start = 1'b0;
      run_until(t + 3);
      chk("rst_armed_pre", armed, 1);
      rst = 1'b1;
      step();
      chk_zero("rst_armed");
      rst = 1'b0;

      // Reset mid-capture, then a fresh capture with a new config
      pat = 0;
      t = cyc + 1;
      step();
      cfg_start(2'b00, 7, 0, 0);
      push_wr(t + 2, 0, t);
      push_wr(t + 3, 1, t + 1);
      step();
      start = 1'b0;
      run_until(t + 3);
      rst = 1'b1;
      step();
      chk_zero("rst_capture");
      rst = 1'b0;
      u = cyc + 1;
      step();
      cfg_start(2'b00, 2, 2, 0);
      push_wr(u + 2, 0, u);
      push_wr(u + 5, 1, u + 3);
      push_wr(u + 8, 2, u + 6);
      step();
      start = 1'b0;
      run_until(u + 9);
      chk("post_rst_done", done, 1);
      chk("post_rst_count", sample_count, 3);
      chk("post_rst_queue_empty", exp_q.size(), 0);

      // start and cfg change during CAPTURE are ignored; start in DONE re-arms
      t = cyc + 1;
      step();
      cfg_start(2'b00, 3, 0, 0);
      for (int i = 0; i < 4; i++) push_wr(t + 2 + i, i, t + i);
      step();
      start = 1'b0;
      run_until(t + 2);
      cfg_start(2'b00, 0, 5, 0);
      step();
      start = 1'b0;
      run_until(t + 6);
      chk("ignore_start_done", done, 1);
      chk("ignore_start_count", sample_count, 4);
      step();
      cfg_start(2'b00, 1, 0, 0);
      push_wr(t + 9, 0, t + 7);
      push_wr(t + 10, 1, t + 8);
      step();
      start = 1'b0;
      chk("rearm_done_clear", done, 0);
      chk("rearm_busy", busy, 1);
      run_until(t + 11);
      chk("rearm_done", done, 1);
      chk("rearm_count", sample_count, 2);
      chk("rearm_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Acquisition sequencer in the `clk_design` domain, downstream of the ADC interface's `adc_ch1`/`adc_ch2` outputs. It arms on a start command, waits for a configurable trigger, then writes a decimated burst of channel-pair samples into an external sample RAM. It reports busy/done status, so software or a higher-level FSM can run back-to-back captures.

## Interface
- `ADDR_W`, 10: sample RAM address width; max capture is 2^ADDR_W pairs.
- `DATA_W`, 14: ADC sample width; samples are signed two's complement.
- `clk_design`  in  1  design clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  global enable; low freezes all sequential state.
- `adc_ch1`, `adc_ch2`  in  DATA_W each  ADC samples, one per cycle.
- `start`  in  1  one-cycle arm request.
- `abort`  in  1  one-cycle cancel request.
- `cfg_len`  in  ADDR_W  samples to capture minus 1.
- `cfg_decim`  in  8  store one sample every cfg_decim+1 cycles.
- `cfg_trig_mode`  in  2  trigger source:
  - 00 = immediate
  - 01 = ch1 rising crossing
  - 10 = ch1 falling crossing
  - 11 = `ext_trig`
- `cfg_thresh`  in  DATA_W  signed trigger threshold.
- `ext_trig`  in  1  external trigger, level-sampled.
- `wr_en`  out  1  RAM write strobe.
- `wr_addr`  out  ADDR_W  RAM write address.
- `wr_data`  out  2*DATA_W  {ch1, ch2}.
- `armed`  out  1  waiting for trigger.
- `busy`  out  1  armed or capturing.
- `done`  out  1  capture complete; sticky.
- `sample_count`  out  ADDR_W+1  samples written in the current or last capture.

## Operation
- Input stage: when `en`=1, `s_ch1`/`s_ch2` take `adc_ch*` every cycle, and `p_ch1` takes the old `s_ch1`.
- `p_valid` clears on arm and sets after the first registered update.
- FSM states are IDLE, ARMED, CAPTURE, DONE.
- IDLE or DONE, `start`=1:
  - Latch all `cfg_*`; clear `done`, `sample_count`, addr, decim_cnt and `p_valid`.
  - Go to CAPTURE if `cfg_trig_mode`=00, otherwise to ARMED.
  - `cfg_*` changes after this latch have no effect until the next start.
- ARMED: go to CAPTURE on the first cycle any of these holds:
  - mode 01: `p_valid` && `p_ch1` < thresh && `s_ch1` >= thresh (signed compare).
  - mode 10: `p_valid` && `p_ch1` >= thresh && `s_ch1` < thresh.
  - mode 11: `ext_trig`=1.
- CAPTURE, each enabled cycle:
  - If decim_cnt==0, issue a write of {`s_ch1`, `s_ch2`} at addr and increment `sample_count`.
  - decim_cnt then wraps from cfg_decim to 0.
  - The write at addr==cfg_len moves the FSM to DONE; otherwise addr increments.
- DONE: `done`=1 and `busy`=0. Hold until `start` (re-arm) or `abort`.
- `abort` in any state → IDLE next cycle and clears `done`. No further writes are issued; a write already registered still completes.
- `start` is ignored in ARMED and CAPTURE.
- `start` and `abort` in the same cycle: abort wins.
- `en`=0: FSM, counters and input registers hold; triggers are ignored; `wr_en` is 0 the following cycle; `start`/`abort` are ignored.
- Reset values:
  - FSM = IDLE.
  - `wr_en`, `armed`, `busy`, `done` = 0.
  - `wr_addr`, `wr_data`, `sample_count` = 0.
  - Internal counters = 0; `p_valid` = 0.
- Reset mid-capture aborts immediately with no further writes.

## Timing
- `wr_en`, `wr_addr`, `wr_data`, `armed`, `busy`, `done` and `sample_count` are all registered outputs.
- Input-to-write latency: `adc_ch*` at cycle k → `s_ch*` at k+1 → `wr_data` at k+2 if a write is decided at k+1.
- Immediate mode: `start` at T → CAPTURE at T+1 → first `wr_en` at T+2 with addr 0, carrying the `adc_ch*` value from T.
- Crossing mode: the crossing sample is `adc_ch1` at cycle k, detected at k+1, CAPTURE from k+2. The first stored pair is the `adc_ch*` value from k+1, and its `wr_en` is at k+3.
- Capture length: (cfg_len+1) writes, consecutive writes spaced (cfg_decim+1) cycles apart when `en` stays high.
- `done` rises the cycle after the last `wr_en`; `busy` falls in the same cycle.
- `armed`=1 exactly while in ARMED.

## Test plan
- Immediate capture, cfg_len=7, cfg_decim=0, ramp input: 8 consecutive writes, addr 0..7, data equal to the ramp delayed 2 cycles. `done`=1 at write+1; `sample_count`=8.
- Rising trigger, thresh=100, ch1 steps 50→150 at cycle k: no write before k+3; the first write holds the k+1 sample. Repeat with thresh=-100 and a negative-to-positive step.
- cfg_decim=3, cfg_len=3, with `en` low 5 cycles mid-capture: writes spaced 4 enabled cycles, total 4 writes, no `wr_en` while `en`=0.
- `abort` during CAPTURE after 2 writes: no further writes, FSM IDLE, `done`=0, `sample_count`=2. Also check that `start`+`abort` in the same cycle from IDLE stays IDLE.
- Reset asserted in ARMED and in CAPTURE: all outputs 0 the next cycle. A subsequent `start` with a new config captures correctly.
- `start` while in CAPTURE is ignored, and a mid-capture `cfg_len` change has no effect. `start` in DONE re-arms and clears `done`.
